byte_transfer_engine: RTL
=========================

BYTE_TRANSFER_ENGINE -- requirements
Module: byte_transfer_engine

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 8, the number of data bits per transfer before the ACK bit.
REQ-002 The block SHALL have the ports below; all signals are active-high unless stated.
- clk  in  1  the single clock.
- resetn  in  1  asynchronous, active-low reset.
- byte_transfer_engine_flop_en  in  1  global flop enable; when 0, all registers hold.
- half_scl  in  1  single-cycle tick marking the end of each half SCL period.
- tx_start  in  1  request to transmit one byte.
- rx_start  in  1  request to receive one byte.
- tx_data  in  DATA_WIDTH  byte to transmit, MSB first.
- rx_send_ack  in  1  ACK value for a read: 1 = drive ACK (SDA low), 0 = NACK.
- sda_in  in  1  sampled SDA line.
- scl_in  in  1  sampled SCL line, used for stretch detection.
- byte_transfer_engine_sda_out_en  out  1  SDA drive enable.
- byte_transfer_engine_sda_out  out  1  SDA drive value.
- byte_transfer_engine_scl_out_en  out  1  SCL drive enable.
- byte_transfer_engine_scl_out  out  1  SCL drive value.
- rx_data  out  DATA_WIDTH  received byte.
- ack_received  out  1  1 = the slave ACKed the last written byte.
- byte_done  out  1  one-cycle pulse marking the end of a transfer.
- busy  out  1  high while a transfer is in progress.

Function
REQ-003 The state machine SHALL have the states IDLE, BIT_LOW, BIT_HIGH, ACK_LOW and ACK_HIGH.
REQ-004 Advance qualifier: every transition and register update SHALL occur only when flop_en=1.
REQ-005 In IDLE with tx_start=1, the block SHALL load tx_data into the shift register, set mode=write, load the bit counter with DATA_WIDTH-1 and move to BIT_LOW on the next edge.
REQ-006 In IDLE with rx_start=1 and tx_start=0, the block SHALL set mode=read and latch rx_send_ack; otherwise it SHALL behave as REQ-005. When tx_start and rx_start are both 1, tx_start SHALL win.
REQ-007 While not in IDLE, the block SHALL ignore tx_start and rx_start.
REQ-008 The transitions SHALL be:
- BIT_LOW -> BIT_HIGH on half_scl.
- BIT_HIGH -> BIT_LOW on half_scl & scl_in when the counter is not 0; the counter decrements on that edge.
- BIT_HIGH -> ACK_LOW on half_scl & scl_in when the counter is 0.
- ACK_LOW -> ACK_HIGH on half_scl.
- ACK_HIGH -> IDLE on half_scl & scl_in.
REQ-009 Clock stretching: in BIT_HIGH or ACK_HIGH with scl_in=0, the block SHALL hold state regardless of half_scl.
REQ-010 In BIT_LOW and ACK_LOW, scl_out SHALL be 0; in BIT_HIGH and ACK_HIGH, scl_out SHALL be 1; scl_out_en SHALL be 1 in every non-IDLE state.
REQ-011 Write mode, BIT_LOW/BIT_HIGH: sda_out_en SHALL be 1 and sda_out SHALL equal the shift-register MSB; the shift register SHALL shift left on the BIT_HIGH exit edge.
REQ-012 Write mode, ACK_LOW/ACK_HIGH: sda_out_en SHALL be 0; on the ACK_HIGH exit edge, ack_received SHALL be set to ~sda_in.
REQ-013 Read mode, BIT states: sda_out_en SHALL be 0; on the BIT_HIGH exit edge, sda_in SHALL shift into the shift-register LSB.
REQ-014 Read mode, ACK states: sda_out_en SHALL be 1 and sda_out SHALL be ~latched rx_send_ack.
REQ-015 On the ACK_HIGH exit edge, rx_data SHALL be loaded from the shift register (read mode only). rx_data and ack_received SHALL hold until the next completed transfer of the same mode.
REQ-016 byte_done SHALL be registered, high for exactly the first cycle back in IDLE. rx_data and ack_received SHALL be valid in that same cycle.
REQ-017 busy SHALL be 1 exactly when the state is not IDLE.
REQ-018 Latency: 2*(DATA_WIDTH+1) qualified half_scl ticks from leaving IDLE to byte_done; 18 for DATA_WIDTH=8.
REQ-019 In IDLE: sda_out_en=0, scl_out_en=0, sda_out=1, scl_out=0.
REQ-020 The bit counter SHALL NOT wrap; exit at 0 is the only path.

Reset
REQ-021 On resetn=0, asynchronously and at any point including mid-byte, the block SHALL enter IDLE and clear the shift register, counter, mode, rx_data, ack_received, byte_done and busy to 0. Both line enables SHALL be released immediately, with sda_out=1 and scl_out=0.
REQ-022 After reset, no transfer SHALL start until a new tx_start or rx_start arrives.

Verification
REQ-023 Write with ACK: tx_start, tx_data=0xA5, sda_in=0 during ACK_HIGH -> SDA bits 1,0,1,0,0,1,0,1; byte_done after 18 ticks; ack_received=1.
REQ-024 Write with NACK: tx_data=0x00, sda_in=1 during ACK -> ack_received=0; busy drops with byte_done.
REQ-025 Read with ACK: rx_start, rx_send_ack=1, slave bits 0x3C -> rx_data=0x3C; sda_out=0 with en=1 during ACK states.
REQ-026 Read with NACK and simultaneous start: tx_start=rx_start=1 -> write performed; then read with rx_send_ack=0 -> sda_out=1 in ACK states.
REQ-027 Clock stretch: hold scl_in=0 for 5 ticks in bit 3 BIT_HIGH -> state, counter and outputs frozen; resumes on scl_in=1; data intact.
REQ-028 Reset mid-byte (after 7 ticks) and start while busy -> immediate IDLE with both enables 0; tx_start during busy ignored and no extra byte_done.

Source files
------------

// File: rtl/byte_transfer_engine.sv
// ---------------------------------------------------------------------------
// byte_transfer_engine
//
// Bit-level engine for an I2C-style master. Shifts one DATA_WIDTH-bit byte
// out on SDA (write) or in from SDA (read), MSB first, followed by one ACK
// bit. SCL is generated from the half_scl tick, and a slave may stretch the
// clock by holding scl_in low while the engine is in a high phase.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   byte_transfer_engine_flop_en    global enable; all registers hold when 0
//   half_scl                        single-cycle tick ending each half SCL period
//   tx_start / rx_start             start a write / read (tx_start wins)
//   tx_data                         byte to write, MSB first
//   rx_send_ack                     ACK to return on a read (1 = ACK, SDA low)
//   sda_in, scl_in                  sampled bus lines
//   byte_transfer_engine_sda_out_en / _sda_out   SDA drive enable / value
//   byte_transfer_engine_scl_out_en / _scl_out   SCL drive enable / value
//   rx_data                         last byte received
//   ack_received                    1 = slave ACKed the last written byte
//   byte_done                       one-cycle pulse on return to IDLE
//   busy                            high while a transfer is in progress
//
// All outputs are registers. They are computed from the next-state values
// so that they line up with the state register in the same cycle.
// ---------------------------------------------------------------------------
module byte_transfer_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  byte_transfer_engine_flop_en,
  input  logic                  half_scl,
  input  logic                  tx_start,
  input  logic                  rx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  rx_send_ack,
  input  logic                  sda_in,
  input  logic                  scl_in,
  output logic                  byte_transfer_engine_sda_out_en,
  output logic                  byte_transfer_engine_sda_out,
  output logic                  byte_transfer_engine_scl_out_en,
  output logic                  byte_transfer_engine_scl_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  ack_received,
  output logic                  byte_done,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIT_LOW  = 3'd1,
    BIT_HIGH = 3'd2,
    ACK_LOW  = 3'd3,
    ACK_HIGH = 3'd4
  } state_t;

  // Line drive for a given state, packed as {sda_en, sda, scl_en, scl}.
  // rd selects read mode; msb is the shift-register MSB; ackv is the
  // latched rx_send_ack. SDA rests at 1 whenever it is not driven.
  function automatic logic [3:0] line_drive(input state_t st, input logic rd,
                                            input logic msb, input logic ackv);
    logic [3:0] d;
    d = {1'b0, 1'b1, 1'b0, 1'b0};
    case (st)
      BIT_LOW:  d = {~rd, rd | msb, 1'b1, 1'b0};
      BIT_HIGH: d = {~rd, rd | msb, 1'b1, 1'b1};
      ACK_LOW:  d = {rd, ~(rd & ackv), 1'b1, 1'b0};
      ACK_HIGH: d = {rd, ~(rd & ackv), 1'b1, 1'b1};
      default:  d = {1'b0, 1'b1, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  mode_r, mode_s;          // 1 = read
  logic                  ack_val_r, ack_val_s;    // latched rx_send_ack
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
  logic                  ack_received_r, ack_received_s;
  logic                  byte_done_r, byte_done_s;
  logic                  busy_r, busy_s;
  logic [3:0]            drive_r, drive_s;
  logic                  high_adv_s;

  // Next-state, datapath and output decode.
  always_comb begin
    state_s        = state_r;
    shift_s        = shift_r;
    cnt_s          = cnt_r;
    mode_s         = mode_r;
    ack_val_s      = ack_val_r;
    rx_data_s      = rx_data_r;
    ack_received_s = ack_received_r;
    byte_done_s    = 1'b0;
    // A high phase only ends once the line is really high (no stretching).
    high_adv_s     = half_scl & scl_in;

    case (state_r)
      IDLE: begin
        if (tx_start) begin
          shift_s = tx_data;
          mode_s  = 1'b0;
          cnt_s   = CNT_LOAD;
          state_s = BIT_LOW;
        end else if (rx_start) begin
          shift_s   = tx_data;
          mode_s    = 1'b1;
          ack_val_s = rx_send_ack;
          cnt_s     = CNT_LOAD;
          state_s   = BIT_LOW;
        end else begin
          state_s = IDLE;
        end
      end
      BIT_LOW: begin
        if (half_scl) begin
          state_s = BIT_HIGH;
        end else begin
          state_s = BIT_LOW;
        end
      end
      BIT_HIGH: begin
        if (high_adv_s) begin
          if (mode_r) begin
            shift_s = {shift_r[DATA_WIDTH-2:0], sda_in};
          end else begin
            shift_s = {shift_r[DATA_WIDTH-2:0], 1'b0};
          end
          // Counter never wraps: reaching 0 is the only way out of the bits.
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_s   = cnt_r - CNT_W'(1);
            state_s = BIT_LOW;
          end else begin
            state_s = ACK_LOW;
          end
        end else begin
          state_s = BIT_HIGH;
        end
      end
      ACK_LOW: begin
        if (half_scl) begin
          state_s = ACK_HIGH;
        end else begin
          state_s = ACK_LOW;
        end
      end
      ACK_HIGH: begin
        if (high_adv_s) begin
          state_s     = IDLE;
          byte_done_s = 1'b1;
          if (mode_r) begin
            rx_data_s = shift_r;
          end else begin
            ack_received_s = ~sda_in;
          end
        end else begin
          state_s = ACK_HIGH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    drive_s = line_drive(state_s, mode_s, shift_s[DATA_WIDTH-1], ack_val_s);
    busy_s  = (state_s != IDLE);
  end

  // State, datapath and output registers, advancing only on flop_en.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= IDLE;
      shift_r        <= {DATA_WIDTH{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      mode_r         <= 1'b0;
      ack_val_r      <= 1'b0;
      rx_data_r      <= {DATA_WIDTH{1'b0}};
      ack_received_r <= 1'b0;
      byte_done_r    <= 1'b0;
      busy_r         <= 1'b0;
      drive_r        <= {1'b0, 1'b1, 1'b0, 1'b0};
    end else if (byte_transfer_engine_flop_en) begin
      state_r        <= state_s;
      shift_r        <= shift_s;
      cnt_r          <= cnt_s;
      mode_r         <= mode_s;
      ack_val_r      <= ack_val_s;
      rx_data_r      <= rx_data_s;
      ack_received_r <= ack_received_s;
      byte_done_r    <= byte_done_s;
      busy_r         <= busy_s;
      drive_r        <= drive_s;
    end
  end

  assign byte_transfer_engine_sda_out_en = drive_r[3];
  assign byte_transfer_engine_sda_out    = drive_r[2];
  assign byte_transfer_engine_scl_out_en = drive_r[1];
  assign byte_transfer_engine_scl_out    = drive_r[0];
  assign rx_data                         = rx_data_r;
  assign ack_received                    = ack_received_r;
  assign byte_done                       = byte_done_r;
  assign busy                            = busy_r;

endmodule
